// File: rtl/cf_sector_writer_pkg.sv
// Shared CF command encodings and sector geometry for the CF write path.
package cf_sector_writer_pkg;

   localparam logic [1:0] CF_CMD_NONE  = 2'b00;
   localparam logic [1:0] CF_CMD_READ  = 2'b01;
   localparam logic [1:0] CF_CMD_WRITE = 2'b10;

   localparam int CF_WORDS_PER_SECTOR = 256;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_ISSUE,
      ST_XFER,
      ST_PAD,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/cf_sector_writer_fifo.sv
// Single-clock show-ahead FIFO: rdata is the head word whenever not empty.
module cf_fifo #(
   parameter int AW = 10,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Pointers carry one extra wrap bit, so count reaches 2**AW only when full.
   assign count   = wr_ptr - rd_ptr;
   assign full    = count[AW];
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/cf_sector_writer.sv
// Buffers audio samples and writes them to CF one sector at a time
// at consecutive LBAs, zero-padding the last sector on stop.
module cf_sector_writer
   import cf_sector_writer_pkg::*;
#(
   parameter int FIFO_AW  = 10,
   parameter int SECTOR_W = CF_WORDS_PER_SECTOR
) (
   input  logic        clk_27mhz,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic [27:0] base_LBA,
   input  logic [15:0] sample,
   input  logic        sample_valid,
   output logic [1:0]  cmd,
   output logic [27:0] LBA,
   output logic [7:0]  SC,
   output logic [15:0] din,
   input  logic        we_req,
   input  logic        ready,
   input  logic        CF_detect,
   input  logic [27:0] LBA_max,
   output logic        busy,
   output logic        overflow,
   output logic        underrun,
   output logic        disk_full,
   output logic [27:0] sectors_done
);

   localparam int PW = $clog2(SECTOR_W);
   localparam logic [FIFO_AW:0] SECT_CNT = (FIFO_AW+1)'(SECTOR_W);
   localparam logic [PW:0]      SECT_WC  = (PW+1)'(SECTOR_W);

   state_t            state;
   logic              stopping;
   logic [27:0]       lba;
   logic [PW:0]       wcnt;
   logic [PW-1:0]     phase;
   logic              run;
   logic              accept;
   logic              pad_push;
   logic              f_push;
   logic              f_pop;
   logic              f_flush;
   logic [15:0]       f_wdata;
   logic [15:0]       f_rdata;
   logic              f_full;
   logic              f_empty;
   logic [FIFO_AW:0]  f_count;
   logic              sect_avail;
   logic              abort;
   logic              lba_over;

   assign run        = (state == ST_FILL) || (state == ST_ISSUE) ||
                       (state == ST_XFER);
   assign accept     = run && !stopping && !stop;
   assign pad_push   = (state == ST_PAD);
   assign f_push     = (accept && sample_valid) || pad_push;
   assign f_wdata    = pad_push ? 16'h0000 : sample;
   assign f_pop      = we_req && (state == ST_XFER);
   assign sect_avail = (f_count >= SECT_CNT) && ready;
   assign abort      = (state != ST_IDLE) && !CF_detect;
   assign lba_over   = sect_avail && (lba > LBA_max) &&
                       (((state == ST_FILL) && !stopping) ||
                        (state == ST_DRAIN));
   assign f_flush    = abort || lba_over ||
                       ((state == ST_IDLE) && start && CF_detect);

   assign LBA  = lba;
   assign SC   = 8'd1;
   assign din  = f_empty ? 16'h0000 : f_rdata;
   assign busy = (state != ST_IDLE);

   cf_fifo #(
      .AW (FIFO_AW),
      .DW (16)
   ) u_fifo (
      .clk   (clk_27mhz),
      .rst   (reset),
      .flush (f_flush),
      .push  (f_push),
      .wdata (f_wdata),
      .pop   (f_pop),
      .rdata (f_rdata),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   always_ff @(posedge clk_27mhz or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         cmd          <= CF_CMD_NONE;
         lba          <= '0;
         stopping     <= 1'b0;
         wcnt         <= '0;
         phase        <= '0;
         overflow     <= 1'b0;
         underrun     <= 1'b0;
         disk_full    <= 1'b0;
         sectors_done <= '0;
      end else begin
         if (f_push && !f_full)          phase    <= phase + 1'b1;
         if (f_pop && !f_empty)          wcnt     <= wcnt + 1'b1;
         if (accept && sample_valid && f_full) overflow <= 1'b1;
         if (f_pop && f_empty)           underrun <= 1'b1;
         if (run && stop)                stopping <= 1'b1;

         if (abort) begin
            state <= ST_IDLE;
            cmd   <= CF_CMD_NONE;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (start && CF_detect) begin
                     lba          <= base_LBA;
                     overflow     <= 1'b0;
                     underrun     <= 1'b0;
                     disk_full    <= 1'b0;
                     sectors_done <= '0;
                     stopping     <= 1'b0;
                     phase        <= '0;
                     state        <= ST_FILL;
                  end
               end
               ST_FILL: begin
                  if (stopping) begin
                     state <= (phase != '0) ? ST_PAD : ST_DRAIN;
                  end else if (lba_over) begin
                     disk_full <= 1'b1;
                     state     <= ST_IDLE;
                  end else if (sect_avail) begin
                     cmd   <= CF_CMD_WRITE;
                     state <= ST_ISSUE;
                  end
               end
               ST_ISSUE: begin
                  cmd   <= CF_CMD_NONE;
                  wcnt  <= '0;
                  state <= ST_XFER;
               end
               ST_XFER: begin
                  if ((wcnt == SECT_WC) && ready) begin
                     lba          <= lba + 28'd1;
                     sectors_done <= sectors_done + 28'd1;
                     if (stopping || stop)
                        state <= (phase != '0) ? ST_PAD : ST_DRAIN;
                     else
                        state <= ST_FILL;
                  end
               end
               ST_PAD: begin
                  // This cycle's zero word lands on the sector boundary.
                  if (phase == '1) state <= ST_DRAIN;
               end
               ST_DRAIN: begin
                  if (f_empty) begin
                     state <= ST_IDLE;
                  end else if (lba_over) begin
                     disk_full <= 1'b1;
                     state     <= ST_IDLE;
                  end else if (sect_avail) begin
                     cmd   <= CF_CMD_WRITE;
                     state <= ST_ISSUE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cf_sector_writer.sv
// Self-checking bench for cf_sector_writer with a behavioural CF write model.
module tb_cf_sector_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        stop;
   logic [27:0] base_lba;
   logic [15:0] sample;
   logic        sample_valid;
   logic [1:0]  cmd;
   logic [27:0] LBA;
   logic [7:0]  SC;
   logic [15:0] din;
   logic        we_req;
   logic        ready;
   logic        model_ready;
   logic        hold;
   logic        cf_detect;
   logic [27:0] lba_max;
   logic        busy;
   logic        overflow;
   logic        underrun;
   logic        disk_full;
   logic [27:0] sectors_done;

   int checks   = 0;
   int failures = 0;

   logic [27:0] cap_lba[$];
   logic [15:0] cap_data[$];

   typedef struct {
      logic [27:0] base;
      logic [27:0] lmax;
      int          nsamp;
      bit          hold;
      int          stored;
      int          sectors;
      bit          ovf;
      bit          dfull;
   } vec_t;

   vec_t tbl[4];

   always #5 clk = ~clk;

   assign ready = model_ready && !hold;

   cf_sector_writer dut (
      .clk_27mhz    (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .base_LBA     (base_lba),
      .sample       (sample),
      .sample_valid (sample_valid),
      .cmd          (cmd),
      .LBA          (LBA),
      .SC           (SC),
      .din          (din),
      .we_req       (we_req),
      .ready        (ready),
      .CF_detect    (cf_detect),
      .LBA_max      (lba_max),
      .busy         (busy),
      .overflow     (overflow),
      .underrun     (underrun),
      .disk_full    (disk_full),
      .sectors_done (sectors_done)
   );

   // CF write model: one command -> 256 randomly spaced we_req pulses.
   initial begin
      int n;
      model_ready = 1'b1;
      we_req      = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && cmd == 2'b10) begin
            cap_lba.push_back(LBA);
            model_ready = 1'b0;
            n = 0;
            while (n < 256) begin
               @(negedge clk);
               if (reset || !cf_detect) begin
                  we_req = 1'b0;
                  break;
               end
               if ($urandom_range(0, 2) != 0) begin
                  we_req = 1'b1;
                  cap_data.push_back(din);
                  n++;
               end else begin
                  we_req = 1'b0;
               end
            end
            if (we_req) begin
               @(negedge clk);
               we_req = 1'b0;
            end
            model_ready = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic wait_idle();
      int cyc = 0;
      while (busy && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk("busy_timeout", {31'b0, busy}, 32'd0);
   endtask

   task automatic run_rec(input vec_t v);
      int errs;
      logic [15:0] exp;
      cap_lba.delete();
      cap_data.delete();
      lba_max = v.lmax;
      hold    = v.hold;
      @(negedge clk);
      base_lba = v.base;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < v.nsamp; i++) begin
         sample       = i[15:0];
         sample_valid = 1'b1;
         @(negedge clk);
      end
      sample_valid = 1'b0;
      hold         = 1'b0;
      stop         = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_idle();
      chk("sectors_done", {4'b0, sectors_done}, v.sectors);
      chk("overflow", {31'b0, overflow}, {31'b0, v.ovf});
      chk("disk_full", {31'b0, disk_full}, {31'b0, v.dfull});
      chk("underrun", {31'b0, underrun}, 32'd0);
      chk("cmd_idle", {30'b0, cmd}, 32'd0);
      chk("lba_end", {4'b0, LBA}, {4'b0, v.base + 28'(v.sectors)});
      chk("n_cmds", cap_lba.size(), v.sectors);
      chk("n_words", cap_data.size(), v.sectors * 256);
      errs = 0;
      foreach (cap_lba[k])
         if (cap_lba[k] !== v.base + 28'(k)) errs++;
      chk("lba_seq", errs, 0);
      errs = 0;
      foreach (cap_data[j]) begin
         exp = (j < v.stored) ? j[15:0] : 16'h0000;
         if (cap_data[j] !== exp) errs++;
      end
      chk("data", errs, 0);
   endtask

   task automatic wait_words(input int n);
      int cyc = 0;
      while (cap_data.size() < n && cyc < 10000) begin
         @(negedge clk);
         cyc++;
      end
      chk("word_timeout", {31'b0, cap_data.size() < n}, 32'd0);
   endtask

   initial begin
      tbl[0] = '{28'd100, 28'd1000,  512, 1'b0,  512, 2, 1'b0, 1'b0};
      tbl[1] = '{28'd200, 28'd1000,  300, 1'b0,  300, 2, 1'b0, 1'b0};
      tbl[2] = '{28'd300, 28'd1000, 1100, 1'b1, 1024, 4, 1'b1, 1'b0};
      tbl[3] = '{28'd4,   28'd5,    1024, 1'b0, 1024, 2, 1'b0, 1'b1};

      reset        = 1'b1;
      start        = 1'b0;
      stop         = 1'b0;
      base_lba     = '0;
      sample       = '0;
      sample_valid = 1'b0;
      hold         = 1'b0;
      cf_detect    = 1'b1;
      lba_max      = 28'd1000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst_cmd", {30'b0, cmd}, 32'd0);
      chk("rst_lba", {4'b0, LBA}, 32'd0);
      chk("rst_din", {16'b0, din}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_flags", {29'b0, overflow, underrun, disk_full}, 32'd0);
      chk("rst_sectors", {4'b0, sectors_done}, 32'd0);
      chk("sc_const", {24'b0, SC}, 32'd1);

      cf_detect = 1'b0;
      base_lba  = 28'd9;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("start_nocard", {31'b0, busy}, 32'd0);
      cf_detect = 1'b1;

      for (int t = 0; t < 4; t++) run_rec(tbl[t]);

      // Card removed while the second sector is in flight.
      cap_lba.delete();
      cap_data.delete();
      lba_max  = 28'd1000;
      base_lba = 28'd10;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 512; i++) begin
         sample       = i[15:0];
         sample_valid = 1'b1;
         @(negedge clk);
      end
      sample_valid = 1'b0;
      wait_words(300);
      cf_detect = 1'b0;
      @(negedge clk);
      chk("det_busy", {31'b0, busy}, 32'd0);
      chk("det_cmd", {30'b0, cmd}, 32'd0);
      chk("det_sectors", {4'b0, sectors_done}, 32'd1);
      chk("det_din", {16'b0, din}, 32'd0);
      cf_detect = 1'b1;
      repeat (3) @(negedge clk);

      // Reset in the middle of a transfer.
      cap_lba.delete();
      cap_data.delete();
      base_lba = 28'd50;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         sample       = i[15:0];
         sample_valid = 1'b1;
         @(negedge clk);
      end
      sample_valid = 1'b0;
      wait_words(100);
      reset = 1'b1;
      @(negedge clk);
      chk("mrst_cmd", {30'b0, cmd}, 32'd0);
      chk("mrst_lba", {4'b0, LBA}, 32'd0);
      chk("mrst_din", {16'b0, din}, 32'd0);
      chk("mrst_busy", {31'b0, busy}, 32'd0);
      chk("mrst_sectors", {4'b0, sectors_done}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      run_rec('{28'd7, 28'd1000, 256, 1'b0, 256, 1, 1'b0, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
